// File: rtl/updown_counter_pkg.sv
// Shared constants for the up/down counter: step-direction encoding and default width.
package updown_counter_pkg;
  localparam logic MODE_DOWN             = 1'b0;
  localparam logic MODE_UP               = 1'b1;
  localparam int   COUNTER_WIDTH_DEFAULT = 4;
endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-count and terminal flag for the up/down counter.
// UPDOWN_COUNTER_SATURATE_EN selects saturating behaviour instead of modulo wrap.
module updown_counter_next
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] value,
  input  logic             mode,
  output logic [WIDTH-1:0] next_value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] v, input logic up);
    return up ? v + ONE : v - ONE;
  endfunction

  function automatic logic is_terminal(input logic [WIDTH-1:0] v, input logic up);
    return up ? (v == ALL_ONES) : (v == ZERO);
  endfunction

  logic up;
  assign up = (mode == MODE_UP);

  always_comb begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
    // Stick at the terminal value; flag whenever the count lands on or stays at it.
    next_value = is_terminal(value, up) ? value : step_value(value, up);
    wrap       = is_terminal(next_value, up);
`else
    next_value = step_value(value, up);
    wrap       = is_terminal(value, up);
`endif
  end

endmodule

// File: rtl/updown_counter.sv
// Synchronous up/down counter with preload and registered wrap detect.
// Optional macro UPDOWN_COUNTER_SATURATE_EN: saturate at the terminal value instead of wrapping.
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             preload,
  input  logic [WIDTH-1:0] preload_data,
  input  logic             mode,
  output logic             detect,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] next_value;
  logic             wrap;

  updown_counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .value     (result),
    .mode      (mode),
    .next_value(next_value),
    .wrap      (wrap)
  );

  // Priority: reset, preload, count, hold; detect only survives a count step.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      detect <= 1'b0;
    end else if (preload) begin
      result <= preload_data;
      detect <= 1'b0;
    end else if (enable) begin
      result <= next_value;
      detect <= wrap;
    end else begin
      detect <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter (WIDTH=4); expected values computed by hand.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       preload;
  logic [3:0] preload_data;
  logic       mode;
  logic       detect;
  logic [3:0] result;

  int checks = 0;
  int errors = 0;

  updown_counter #(
    .WIDTH(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .preload     (preload),
    .preload_data(preload_data),
    .mode        (mode),
    .detect      (detect),
    .result      (result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] r_exp, input logic d_exp);
    checks++;
    assert (result === r_exp && detect === d_exp)
    else begin
      errors++;
      $error("FAIL %s result=%h detect=%b expected result=%h detect=%b",
             tag, result, detect, r_exp, d_exp);
    end
  endtask

  task automatic do_preload(input logic [3:0] v, input logic m);
    preload      = 1'b1;
    preload_data = v;
    mode         = m;
    tick();
    check("preload", v, 1'b0);
    preload = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    preload      = 1'b0;
    preload_data = 4'h0;
    mode         = 1'b1;

    tick(); check("reset0", 4'h0, 1'b0);
    tick(); check("reset1", 4'h0, 1'b0);

    reset = 1'b0;
    tick(); check("up1", 4'h1, 1'b0);
    tick(); check("up2", 4'h2, 1'b0);
    tick(); check("up3", 4'h3, 1'b0);

`ifndef UPDOWN_COUNTER_SATURATE_EN
    do_preload(4'hD, 1'b1);
    tick(); check("up_e", 4'hE, 1'b0);
    tick(); check("up_f", 4'hF, 1'b0);
    tick(); check("up_wrap", 4'h0, 1'b1);
    tick(); check("up_after", 4'h1, 1'b0);

    do_preload(4'h2, 1'b0);
    tick(); check("dn_1", 4'h1, 1'b0);
    tick(); check("dn_0", 4'h0, 1'b0);
    tick(); check("dn_wrap", 4'hF, 1'b1);
    tick(); check("dn_after", 4'hE, 1'b0);

    // Hold right after a wrap clears detect.
    do_preload(4'hF, 1'b1);
    tick(); check("wrap_hold_pre", 4'h0, 1'b1);
    enable = 1'b0;
    tick(); check("hold_clr_det", 4'h0, 1'b0);
    enable = 1'b1;

    // Reset right after a wrap clears detect.
    do_preload(4'hF, 1'b1);
    tick(); check("wrap_rst_pre", 4'h0, 1'b1);
    reset = 1'b1;
    tick(); check("rst_clr_det", 4'h0, 1'b0);
    reset = 1'b0;

    // Preload right after a wrap clears detect.
    do_preload(4'h0, 1'b0);
    tick(); check("wrap_pl_pre", 4'hF, 1'b1);
    do_preload(4'h6, 1'b1);
`else
    do_preload(4'hE, 1'b1);
    tick(); check("sat_up_f", 4'hF, 1'b1);
    tick(); check("sat_up_hold", 4'hF, 1'b1);
    mode = 1'b0;
    tick(); check("sat_turn_dn", 4'hE, 1'b0);

    do_preload(4'h1, 1'b0);
    tick(); check("sat_dn_0", 4'h0, 1'b1);
    tick(); check("sat_dn_hold", 4'h0, 1'b1);
    enable = 1'b0;
    tick(); check("sat_dis_det", 4'h0, 1'b0);
    enable = 1'b1;
`endif

    // Disabled for 5 cycles with mode toggling.
    do_preload(4'h7, 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mode = ~mode;
      tick(); check("hold", 4'h7, 1'b0);
    end
    enable = 1'b1;

    // Reset beats preload.
    reset        = 1'b1;
    preload      = 1'b1;
    preload_data = 4'h9;
    tick(); check("rst_over_pl", 4'h0, 1'b0);
    reset   = 1'b0;
    preload = 1'b0;

    // Preload beats count.
    enable = 1'b1;
    do_preload(4'h9, 1'b1);

    // Mode flip mid-sequence without a bubble.
    do_preload(4'h4, 1'b1);
    tick(); check("flip_up", 4'h5, 1'b0);
    mode = 1'b0;
    tick(); check("flip_dn", 4'h4, 1'b0);
    tick(); check("flip_dn2", 4'h3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout result=%h detect=%b expected completion", result, detect);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/updown_counter.md
# updown_counter

- Parameterized synchronous up/down counter with load-on-demand preload and a registered terminal-count (wrap) detect flag.
- Sits as a leaf block: it drives `result` and `detect` to downstream control logic.
- It is exercised by the `testcase` stimulus block through a shared set of signals.
- Single clock domain, no handshakes.

## Interface
- `WIDTH`, default 4: counter and preload data width in bits (≥ 2).

- `clk` input 1: rising-edge clock; the only clock.
- `reset` input 1: reset is synchronous and active-high.
- `enable` input 1: count enable; when low, the count holds.
- `preload` input 1: load `preload_data` into the counter on this edge.
- `preload_data` input WIDTH: value loaded when `preload`=1.
- `mode` input 1: 1 = count up, 0 = count down.
- `detect` output 1: registered; high for one cycle after a wrap.
- `result` output WIDTH: registered counter value.

## Operation
Priority at each rising `clk` edge, highest first:
1. **Reset.** `reset`=1 → `result`←0, `detect`←0.
2. **Preload.** `preload`=1 → `result`←`preload_data`, `detect`←0. This is independent of `enable` and `mode`.
3. **Count.** `enable`=1:
   - Up mode: `result`←`result`+1, modulo 2^WIDTH.
   - Down mode: `result`←`result`−1, modulo 2^WIDTH.
4. **Hold.** Otherwise `result` holds and `detect`←0.

Wrap rules:
- A wrap occurs on a count step from all-ones to 0 (up) or from 0 to all-ones (down).
- The wrap edge sets `detect`←1. Every other count step sets `detect`←0.
- `mode` is sampled every edge and may change on any cycle. The step direction follows `mode` at that edge.
- Arithmetic is unsigned, WIDTH bits, with no carry-out port.

## Timing
- All outputs are registered, with no combinational input→output paths.
- Reset value: `result`=0, `detect`=0. Both are valid on the first edge with `reset`=1.
- Latency:
  - Count step: 1 cycle.
  - Preload: 1 cycle (value visible after the edge).
  - `detect`: coincides with the edge that produces the wrapped `result` value.
- `detect` pulses for exactly 1 cycle per wrap. Continuous counting gives one pulse every 2^WIDTH enabled cycles.
- Simultaneous events:
  - `reset` and `preload` both high → reset wins.
  - `preload` and `enable` both high → preload wins and no count step occurs.
- Reset mid-count: the next edge forces 0 and clears any pending `detect`.
- A mode change mid-sequence has no bubble. Example: 0x5 up → mode flips → 0x4 next enabled edge.

## Configuration
- `UPDOWN_COUNTER_SATURATE_EN`
  - **Defined:**
    - The counter saturates instead of wrapping: it holds all-ones in up mode and holds 0 in down mode.
    - `detect` is high every cycle `result` sits at the terminal value for the current `mode` with `enable`=1.
  - **Undefined (default):** modulo wrap with one-cycle `detect` pulses, as above.

## Structure
- Package `updown_counter_pkg`:
  - Mode constants `MODE_DOWN`=1'b0 and `MODE_UP`=1'b1.
  - Default width constant `COUNTER_WIDTH_DEFAULT`=4.
- One sub-module `updown_counter_next`, purely combinational:
  - Inputs: current value and mode.
  - Outputs: next value and a wrap/terminal flag.
  - The top holds only the `result`/`detect` registers and the priority mux.

## Test plan
- Assert `reset` for 2 cycles with `enable`=1 → `result`=0 and `detect`=0 on both cycles. Then release with `mode`=1 → `result` 1,2,3 on successive edges.
- `preload`=1, `preload_data`=0xD, `enable`=1, `mode`=1 → `result`=0xD. Then count up → 0xE, 0xF, 0x0 with `detect`=1 only on the 0x0 cycle, then 0x1 with `detect`=0.
- Preload 0x2, `mode`=0 → 0x1, 0x0, 0xF with `detect`=1 on the 0xF cycle, then 0xE with `detect`=0.
- `enable`=0 for 5 cycles at `result`=0x7 with `mode` toggling → `result` stays 0x7 and `detect` stays 0.
- Same-edge priority cases:
  - `reset`, `preload`=1 and `preload_data`=0x9 on one edge → `result`=0.
  - `preload` and `enable` on one edge → `result`=`preload_data`, with no increment.
- Saturation with `UPDOWN_COUNTER_SATURATE_EN` defined:
  - Preload 0xE, count up → 0xF, then 0xF; `detect` is high on both 0xF cycles.
